// File: rtl/rf_sched_pkg.sv
// Shared types and helpers for the register-file access scheduler.
package rf_sched_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  // Packed request buses are widened to this size before field extraction.
  localparam int PACK_MAX_W = 1024;
  typedef logic [PACK_MAX_W-1:0] pack_vec_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int warp_w(input int num_warps);
    return idx_w(num_warps);
  endfunction

  function automatic int addr_w(input int num_regs);
    return idx_w(num_regs);
  endfunction

  // Field idx of width w (w <= 32) from a packed bus.
  function automatic logic [31:0] field_at(input pack_vec_t vec, input int idx, input int w);
    pack_vec_t sh;
    sh = vec >> (idx * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/rf_access_sched_rr_arbiter.sv
// Stateless round-robin picker: first requester at or after ptr, with wrap-around.
module rr_arbiter
  import rf_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  always_comb begin
    logic found;
    int   j;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (en && !found && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_access_sched.sv
// Per-cycle scheduler sharing the register file's warp selector and ports;
// zeroes the whole file after reset, then grants one read or one write per cycle.
module rf_access_sched
  import rf_sched_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int NUM_WARPS  = 16,
  parameter  int NUM_REGS   = 64,
  parameter  int NUM_LANES  = 16,
  parameter  int STARVE_MAX = 4,
  localparam int WARP_W     = warp_w(NUM_WARPS),
  localparam int ADDR_W     = addr_w(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            rd_req_valid,
  input  logic [NUM_REQ*WARP_W-1:0]     rd_req_warp,
  input  logic [NUM_REQ*ADDR_W-1:0]     rd_req_raddr0,
  input  logic [NUM_REQ*ADDR_W-1:0]     rd_req_raddr1,
  input  logic [NUM_REQ*NUM_LANES-1:0]  rd_req_mask0,
  input  logic [NUM_REQ*NUM_LANES-1:0]  rd_req_mask1,
  output logic [NUM_REQ-1:0]            rd_req_ready,
  input  logic                          wb_valid,
  input  logic [WARP_W-1:0]             wb_warp,
  input  logic [ADDR_W-1:0]             wb_addr,
  input  logic [NUM_LANES-1:0]          wb_mask,
  output logic                          wb_ready,
  output logic [WARP_W-1:0]             warp_selector,
  output logic [NUM_LANES-1:0]          read_en_0,
  output logic [NUM_LANES-1:0]          read_en_1,
  output logic [ADDR_W-1:0]             raddr_0,
  output logic [ADDR_W-1:0]             raddr_1,
  output logic [NUM_LANES-1:0]          write_en,
  output logic [ADDR_W-1:0]             waddr,
  output logic                          wdata_clear,
  output logic                          init_done
);

  localparam int PTR_W = idx_w(NUM_REQ);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  sched_state_t          state;
  logic                  clr_go;
  logic [WARP_W-1:0]     warp_cnt;
  logic [ADDR_W-1:0]     reg_cnt;
  logic [PTR_W-1:0]      rr_ptr;
  logic [SC_W-1:0]       starve_cnt;
  logic [WARP_W-1:0]     warp_q;
  logic [ADDR_W-1:0]     waddr_q;
  logic [ADDR_W-1:0]     raddr0_q;
  logic [ADDR_W-1:0]     raddr1_q;

  logic                  run;
  logic                  any_rd;
  logic                  wr_win;
  logic                  rd_win;
  logic                  clr_last;
  logic [NUM_REQ-1:0]    rd_gnt;
  logic [PTR_W-1:0]      rd_idx;

  assign run      = (state == ST_RUN);
  assign any_rd   = |rd_req_valid;
  assign wr_win   = run && wb_valid && (!any_rd || (starve_cnt < SC_W'(STARVE_MAX)));
  assign rd_win   = |rd_gnt;
  assign clr_last = (warp_cnt == WARP_W'(NUM_WARPS - 1)) && (reg_cnt == ADDR_W'(NUM_REGS - 1));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (rd_req_valid),
    .ptr     (rr_ptr),
    .en      (run && !wr_win),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx)
  );

  always_comb begin
    rd_req_ready  = '0;
    wb_ready      = 1'b0;
    warp_selector = warp_q;
    read_en_0     = '0;
    read_en_1     = '0;
    raddr_0       = raddr0_q;
    raddr_1       = raddr1_q;
    write_en      = '0;
    waddr         = waddr_q;
    wdata_clear   = 1'b0;
    if (state == ST_INIT) begin
      if (clr_go) begin
        warp_selector = warp_cnt;
        waddr         = reg_cnt;
        write_en      = '1;
        wdata_clear   = 1'b1;
      end
    end else if (wr_win) begin
      wb_ready      = 1'b1;
      warp_selector = wb_warp;
      waddr         = wb_addr;
      write_en      = wb_mask;
    end else if (rd_win) begin
      rd_req_ready  = rd_gnt;
      warp_selector = WARP_W'(field_at(pack_vec_t'(rd_req_warp), int'(rd_idx), WARP_W));
      raddr_0       = ADDR_W'(field_at(pack_vec_t'(rd_req_raddr0), int'(rd_idx), ADDR_W));
      raddr_1       = ADDR_W'(field_at(pack_vec_t'(rd_req_raddr1), int'(rd_idx), ADDR_W));
      read_en_0     = NUM_LANES'(field_at(pack_vec_t'(rd_req_mask0), int'(rd_idx), NUM_LANES));
      read_en_1     = NUM_LANES'(field_at(pack_vec_t'(rd_req_mask1), int'(rd_idx), NUM_LANES));
    end
  end

  // clr_go delays the clear by one edge so reset itself never drives a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      clr_go     <= 1'b0;
      warp_cnt   <= '0;
      reg_cnt    <= '0;
      init_done  <= 1'b0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
      warp_q     <= '0;
      waddr_q    <= '0;
      raddr0_q   <= '0;
      raddr1_q   <= '0;
    end else begin
      warp_q   <= warp_selector;
      waddr_q  <= waddr;
      raddr0_q <= raddr_0;
      raddr1_q <= raddr_1;
      case (state)
        ST_INIT: begin
          if (!clr_go) begin
            clr_go <= 1'b1;
          end else if (clr_last) begin
            state     <= ST_RUN;
            clr_go    <= 1'b0;
            init_done <= 1'b1;
          end else if (reg_cnt == ADDR_W'(NUM_REGS - 1)) begin
            reg_cnt  <= '0;
            warp_cnt <= warp_cnt + WARP_W'(1);
          end else begin
            reg_cnt <= reg_cnt + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          if (rd_win) begin
            rr_ptr <= (rd_idx == PTR_W'(NUM_REQ - 1)) ? '0 : rd_idx + PTR_W'(1);
          end
          if (wr_win && any_rd) begin
            starve_cnt <= (starve_cnt == SC_W'(STARVE_MAX)) ? starve_cnt : starve_cnt + SC_W'(1);
          end else begin
            starve_cnt <= '0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
